mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MEM_LAT, default 2, memory access latency in cycles; legal range 1..15.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_if  input  1  instruction-fetch port read request; held high until done_if.
REQ-005 req_mem  input  1  data port request; held high until done_mem.
REQ-006 mem_we_in  input  1  data port write flag; valid while req_mem is high.
REQ-007 gnt_if  output  1  one-cycle pulse: fetch port granted.
REQ-008 gnt_mem  output  1  one-cycle pulse: data port granted.
REQ-009 addr_sel  output  1  shared 2:1 address/data mux select; 0 = fetch (in1), 1 = data (in2).
REQ-010 mem_en  output  1  memory enable; high for the whole access.
REQ-011 mem_we  output  1  memory write enable; high only during data-port write accesses.
REQ-012 done_if  output  1  one-cycle pulse: fetch access complete.
REQ-013 done_mem  output  1  one-cycle pulse: data access complete.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-016 All outputs SHALL be registered; no output SHALL depend combinationally on the inputs.
REQ-017 IDLE: request(s) seen at a rising edge -> same edge enters ACCESS; no request -> remains IDLE.
REQ-018 Single request in IDLE: that port wins.
REQ-019 Both requests in IDLE: round-robin; the port NOT granted last wins; last_grant SHALL update on every grant.
REQ-020 On entering ACCESS: gnt_<winner>=1 for exactly the first ACCESS cycle; addr_sel=winner; mem_en=1; mem_we=mem_we_in if winner is data port, else 0.
REQ-021 addr_sel, mem_we and winner SHALL be latched at grant and held constant through ACCESS and DONE.
REQ-022 A 4-bit counter SHALL load MEM_LAT-1 on grant and decrement each ACCESS cycle; ACCESS lasts exactly MEM_LAT cycles.
REQ-023 Counter == 0 in ACCESS -> DONE at the next edge; mem_en=0 and mem_we=0 in DONE.
REQ-024 DONE lasts one cycle: done_<winner>=1; then -> IDLE unconditionally.
REQ-025 One access occupies MEM_LAT+2 cycles (ACCESS, DONE, IDLE); the next grant is earliest at the edge ending that IDLE cycle.
REQ-026 Requester deasserting its request during ACCESS SHALL NOT abort the access; done still pulses.
REQ-027 Change of mem_we_in after grant SHALL be ignored.
REQ-028 In IDLE, addr_sel SHALL hold its last value (no toggling without a grant).
REQ-029 gnt_if/gnt_mem never high together; likewise done_if/done_mem; mem_we never high while mem_en is low.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, counter 0, last_grant = data port (so fetch wins the first tie), all outputs 0 (addr_sel=0).
REQ-031 Reset asserted mid-ACCESS SHALL abort the access with no done pulse; after release, arbitration restarts from IDLE.
REQ-032 Reset release SHALL take effect at the next rising edge; outputs stay 0 until a grant.

Verification
REQ-033 MEM_LAT=2, req_if only -> gnt_if cycle 1, mem_en cycles 1-2, addr_sel=0, done_if cycle 3, busy low cycle 4.
REQ-034 After reset, req_if and req_mem together, held -> grants alternate IF, MEM, IF, MEM; each grant 4 cycles apart.
REQ-035 req_mem, mem_we_in=1, MEM_LAT=3 -> addr_sel=1, mem_en=mem_we=1 for 3 cycles, done_mem on the 4th cycle; flipping mem_we_in mid-access has no effect.
REQ-036 rst_n pulled low in the 2nd ACCESS cycle -> all outputs 0 immediately, no done pulse; after release, pending req_mem granted.
REQ-037 MEM_LAT=1 back-to-back req_if -> gnt_if every 3 cycles; req_if dropped mid-access -> done_if still pulses.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: instruction-fetch and data ports share one memory
// through a 2:1 mux, with round-robin on ties and a fixed MEM_LAT-cycle access.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_if,
    input  logic req_mem,
    input  logic mem_we_in,
    output logic gnt_if,
    output logic gnt_mem,
    output logic addr_sel,
    output logic mem_en,
    output logic mem_we,
    output logic done_if,
    output logic done_mem,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;
    logic       last_grant_r;
    logic       last_grant_nxt_s;
    logic       we_lat_r;
    logic       we_lat_nxt_s;

    logic       gnt_if_r,   gnt_if_nxt_s;
    logic       gnt_mem_r,  gnt_mem_nxt_s;
    logic       addr_sel_r, addr_sel_nxt_s;
    logic       mem_en_r,   mem_en_nxt_s;
    logic       mem_we_r,   mem_we_nxt_s;
    logic       done_if_r,  done_if_nxt_s;
    logic       done_mem_r, done_mem_nxt_s;
    logic       busy_r,     busy_nxt_s;

    logic       any_req_s;
    logic       grant_data_s;

    // Data port wins when it is alone, or on a tie when fetch was granted last.
    assign any_req_s    = req_if | req_mem;
    assign grant_data_s = req_mem & (~req_if | (last_grant_r == 1'b0));

    // State, counter, arbitration history and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            last_grant_r <= 1'b1;
            we_lat_r     <= 1'b0;
            gnt_if_r     <= 1'b0;
            gnt_mem_r    <= 1'b0;
            addr_sel_r   <= 1'b0;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            done_if_r    <= 1'b0;
            done_mem_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            cnt_r        <= cnt_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            we_lat_r     <= we_lat_nxt_s;
            gnt_if_r     <= gnt_if_nxt_s;
            gnt_mem_r    <= gnt_mem_nxt_s;
            addr_sel_r   <= addr_sel_nxt_s;
            mem_en_r     <= mem_en_nxt_s;
            mem_we_r     <= mem_we_nxt_s;
            done_if_r    <= done_if_nxt_s;
            done_mem_r   <= done_mem_nxt_s;
            busy_r       <= busy_nxt_s;
        end
    end

    // Next-state, latency counter and round-robin history.
    always_comb begin
        next_state_s     = state_r;
        cnt_nxt_s        = cnt_r;
        last_grant_nxt_s = last_grant_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    next_state_s     = ACCESS;
                    cnt_nxt_s        = LAT_LOAD;
                    last_grant_nxt_s = grant_data_s;
                end else begin
                    next_state_s     = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = DONE;
                end else begin
                    cnt_nxt_s    = cnt_r - 4'd1;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
                cnt_nxt_s    = 4'd0;
            end
        endcase
    end

    // Next values of the registered outputs; the mux select and write flag are
    // captured at grant so later input changes cannot disturb an access.
    always_comb begin
        gnt_if_nxt_s   = 1'b0;
        gnt_mem_nxt_s  = 1'b0;
        done_if_nxt_s  = 1'b0;
        done_mem_nxt_s = 1'b0;
        mem_en_nxt_s   = 1'b0;
        mem_we_nxt_s   = 1'b0;
        addr_sel_nxt_s = addr_sel_r;
        we_lat_nxt_s   = we_lat_r;
        busy_nxt_s     = (next_state_s != IDLE);
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    gnt_if_nxt_s   = ~grant_data_s;
                    gnt_mem_nxt_s  = grant_data_s;
                    addr_sel_nxt_s = grant_data_s;
                    we_lat_nxt_s   = grant_data_s & mem_we_in;
                    mem_en_nxt_s   = 1'b1;
                    mem_we_nxt_s   = grant_data_s & mem_we_in;
                end else begin
                    addr_sel_nxt_s = addr_sel_r;
                end
            end
            ACCESS: begin
                if (cnt_r == 4'd0) begin
                    done_if_nxt_s  = ~addr_sel_r;
                    done_mem_nxt_s = addr_sel_r;
                end else begin
                    mem_en_nxt_s   = 1'b1;
                    mem_we_nxt_s   = we_lat_r;
                end
            end
            DONE: begin
                addr_sel_nxt_s = addr_sel_r;
            end
            default: begin
                addr_sel_nxt_s = 1'b0;
                we_lat_nxt_s   = 1'b0;
            end
        endcase
    end

    assign gnt_if   = gnt_if_r;
    assign gnt_mem  = gnt_mem_r;
    assign addr_sel = addr_sel_r;
    assign mem_en   = mem_en_r;
    assign mem_we   = mem_we_r;
    assign done_if  = done_if_r;
    assign done_mem = done_mem_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LAT = 1, 2 and 3; output vectors
// are packed {gnt_if,gnt_mem,addr_sel,mem_en,mem_we,done_if,done_mem,busy}.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    logic req_if;
    logic req_mem;
    logic mem_we_in;

    logic gnt_if1, gnt_mem1, addr_sel1, mem_en1, mem_we1, done_if1, done_mem1, busy1;
    logic gnt_if2, gnt_mem2, addr_sel2, mem_en2, mem_we2, done_if2, done_mem2, busy2;
    logic gnt_if3, gnt_mem3, addr_sel3, mem_en3, mem_we3, done_if3, done_mem3, busy3;

    logic [7:0] v1_s, v2_s, v3_s;

    int checks_r;
    int failures_r;

    mem_port_arbiter #(.MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req_if(req_if), .req_mem(req_mem), .mem_we_in(mem_we_in),
        .gnt_if(gnt_if1), .gnt_mem(gnt_mem1), .addr_sel(addr_sel1), .mem_en(mem_en1),
        .mem_we(mem_we1), .done_if(done_if1), .done_mem(done_mem1), .busy(busy1)
    );

    mem_port_arbiter #(.MEM_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .req_if(req_if), .req_mem(req_mem), .mem_we_in(mem_we_in),
        .gnt_if(gnt_if2), .gnt_mem(gnt_mem2), .addr_sel(addr_sel2), .mem_en(mem_en2),
        .mem_we(mem_we2), .done_if(done_if2), .done_mem(done_mem2), .busy(busy2)
    );

    mem_port_arbiter #(.MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .req_if(req_if), .req_mem(req_mem), .mem_we_in(mem_we_in),
        .gnt_if(gnt_if3), .gnt_mem(gnt_mem3), .addr_sel(addr_sel3), .mem_en(mem_en3),
        .mem_we(mem_we3), .done_if(done_if3), .done_mem(done_mem3), .busy(busy3)
    );

    assign v1_s = {gnt_if1, gnt_mem1, addr_sel1, mem_en1, mem_we1, done_if1, done_mem1, busy1};
    assign v2_s = {gnt_if2, gnt_mem2, addr_sel2, mem_en2, mem_we2, done_if2, done_mem2, busy2};
    assign v3_s = {gnt_if3, gnt_mem3, addr_sel3, mem_en3, mem_we3, done_if3, done_mem3, busy3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks_r = checks_r + 1;
        if (obs !== exp) begin
            failures_r = failures_r + 1;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset all instances; returns 1 unit into cycle 0 with requests low.
    task automatic do_reset();
        req_if    = 1'b0;
        req_mem   = 1'b0;
        mem_we_in = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        checks_r   = 0;
        failures_r = 0;
        req_if     = 1'b0;
        req_mem    = 1'b0;
        mem_we_in  = 1'b0;
        rst_n      = 1'b0;
        #3;
        check_eq("reset_lat1", v1_s, 8'b0000_0000);
        check_eq("reset_lat2", v2_s, 8'b0000_0000);
        check_eq("reset_lat3", v3_s, 8'b0000_0000);

        // Single fetch request, MEM_LAT=2.
        do_reset();
        check_eq("if_only_c0", v2_s, 8'b0000_0000);
        req_if = 1'b1;
        tick(); check_eq("if_only_gnt_c1", v2_s, 8'b1001_0001);
        tick(); check_eq("if_only_acc_c2", v2_s, 8'b0001_0001);
        tick(); check_eq("if_only_done_c3", v2_s, 8'b0000_0101);
        req_if = 1'b0;
        tick(); check_eq("if_only_idle_c4", v2_s, 8'b0000_0000);

        // Both requests held: IF, MEM, IF, MEM, four cycles apart.
        do_reset();
        req_if  = 1'b1;
        req_mem = 1'b1;
        tick(); check_eq("rr_gnt_if_c1", v2_s, 8'b1001_0001);
        repeat (3) tick();
        check_eq("rr_idle_c4", v2_s, 8'b0000_0000);
        tick(); check_eq("rr_gnt_mem_c5", v2_s, 8'b0111_0001);
        repeat (2) tick();
        check_eq("rr_done_mem_c7", v2_s, 8'b0010_0011);
        tick(); check_eq("rr_idle_hold_c8", v2_s, 8'b0010_0000);
        tick(); check_eq("rr_gnt_if_c9", v2_s, 8'b1001_0001);
        repeat (4) tick();
        check_eq("rr_gnt_mem_c13", v2_s, 8'b0111_0001);

        // Data write, MEM_LAT=3, mem_we_in flipped after grant.
        do_reset();
        req_mem   = 1'b1;
        mem_we_in = 1'b1;
        tick(); check_eq("wr_gnt_c1", v3_s, 8'b0111_1001);
        mem_we_in = 1'b0;
        tick(); check_eq("wr_acc_c2", v3_s, 8'b0011_1001);
        tick(); check_eq("wr_acc_c3", v3_s, 8'b0011_1001);
        tick(); check_eq("wr_done_c4", v3_s, 8'b0010_0011);
        req_mem = 1'b0;
        tick(); check_eq("wr_idle_c5", v3_s, 8'b0010_0000);

        // Reset pulled in the second ACCESS cycle, MEM_LAT=2.
        do_reset();
        req_mem = 1'b1;
        tick(); check_eq("rst_gnt_c1", v2_s, 8'b0111_0001);
        tick(); check_eq("rst_acc_c2", v2_s, 8'b0011_0001);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_clear", v2_s, 8'b0000_0000);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("rst_released_idle", v2_s, 8'b0000_0000);
        tick(); check_eq("rst_regrant_mem", v2_s, 8'b0111_0001);
        tick(); check_eq("rst_regrant_acc", v2_s, 8'b0011_0001);
        tick(); check_eq("rst_regrant_done", v2_s, 8'b0010_0011);
        req_mem = 1'b0;

        // MEM_LAT=1 back-to-back fetches, then a request dropped mid-access.
        do_reset();
        req_if = 1'b1;
        tick(); check_eq("lat1_gnt_c1", v1_s, 8'b1001_0001);
        tick(); check_eq("lat1_done_c2", v1_s, 8'b0000_0101);
        tick(); check_eq("lat1_idle_c3", v1_s, 8'b0000_0000);
        tick(); check_eq("lat1_gnt_c4", v1_s, 8'b1001_0001);
        req_if = 1'b0;
        tick(); check_eq("lat1_drop_done_c5", v1_s, 8'b0000_0101);
        tick(); check_eq("lat1_idle_c6", v1_s, 8'b0000_0000);
        tick(); check_eq("lat1_no_gnt_c7", v1_s, 8'b0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
